// File: rtl/tau_gemm_stream.sv
// tau_gemm_stream: streaming bit-serial outer-product accumulator.
// A ROWS x COLS grid of unsigned accumulators is updated one operand beat
// (A column, B row) at a time; each beat is consumed over WIDTH cycles,
// one bit of B per cycle, adding the shifted A element wherever that bit is set.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for a command; cmd_ready high
// S_LOAD    | waiting for the next operand beat; op_ready high
// S_COMPUTE | bit-serial accumulation of the latched beat, WIDTH cycles
// S_DRAIN   | result held on out_acc; out_valid high until consumed
module tau_gemm_stream #(
  parameter int ROWS     = 4,
  parameter int COLS     = 4,
  parameter int WIDTH    = 8,
  parameter int MAX_K    = 16,
  parameter int ACC_BITS = 2*WIDTH + $clog2(MAX_K) + 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [$clog2(MAX_K):0]        cmd_k_len,
  input  logic                          cmd_accumulate,
  input  logic                          op_valid,
  output logic                          op_ready,
  input  logic [ROWS*WIDTH-1:0]         op_a,
  input  logic [COLS*WIDTH-1:0]         op_b,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [ROWS*COLS*ACC_BITS-1:0] out_acc,
  output logic                          busy
);

  localparam int KW   = $clog2(MAX_K) + 1;
  localparam int CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int NACC = ROWS * COLS;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOAD    = 2'd1,
    S_COMPUTE = 2'd2,
    S_DRAIN   = 2'd3
  } state_t;

  state_t                   state_q, state_d;
  logic [KW-1:0]            k_q, k_d;
  logic [KW-1:0]            step_q, step_d;
  logic [CW-1:0]            bit_q, bit_d;
  logic [ROWS*WIDTH-1:0]    a_q, a_d;
  logic [COLS*WIDTH-1:0]    b_q, b_d;
  logic [NACC*ACC_BITS-1:0] acc_q, acc_d;
  logic                     cmd_ready_q, cmd_ready_d;
  logic                     op_ready_q, op_ready_d;
  logic                     out_valid_q, out_valid_d;
  logic                     busy_q, busy_d;

  logic                     cmd_fire;
  logic                     op_fire;
  logic                     out_fire;
  logic                     last_bit;
  logic                     last_step;
  logic [KW-1:0]            k_clamped;

  // The ready/valid flags are registered copies of the state decode, so the
  // handshake qualifiers below are equivalent to testing state_q directly.
  assign cmd_fire  = cmd_valid & cmd_ready_q;
  assign op_fire   = op_valid & op_ready_q;
  assign out_fire  = out_ready & out_valid_q;
  assign last_bit  = (bit_q == CW'(WIDTH - 1));
  assign last_step = (step_q == (k_q - KW'(1)));
  assign k_clamped = (cmd_k_len > KW'(MAX_K)) ? KW'(MAX_K) : cmd_k_len;

  // Per-cell addend for the current bit: the A element shifted by the bit
  // index, gated by the matching bit of the B element.
  logic [ACC_BITS-1:0] a_shift [ROWS];
  logic [COLS-1:0]     b_bit;

  for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
    logic [WIDTH-1:0] a_elem;
    assign a_elem      = a_q[gi*WIDTH +: WIDTH];
    assign a_shift[gi] = {{(ACC_BITS-WIDTH){1'b0}}, a_elem} << bit_q;
  end

  for (genvar gj = 0; gj < COLS; gj++) begin : g_col
    logic [WIDTH-1:0] b_elem;
    assign b_elem    = b_q[gj*WIDTH +: WIDTH];
    assign b_bit[gj] = b_elem[bit_q];
  end

  // Next-state, counter and operand-latch logic.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    step_d  = step_q;
    bit_d   = bit_q;
    a_d     = a_q;
    b_d     = b_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_fire) begin
          k_d     = k_clamped;
          step_d  = '0;
          state_d = (k_clamped == '0) ? S_DRAIN : S_LOAD;
        end
      end
      S_LOAD: begin
        if (op_fire) begin
          a_d     = op_a;
          b_d     = op_b;
          bit_d   = '0;
          state_d = S_COMPUTE;
        end
      end
      S_COMPUTE: begin
        if (last_bit) begin
          if (last_step) begin
            state_d = S_DRAIN;
          end else begin
            step_d  = step_q + KW'(1);
            state_d = S_LOAD;
          end
        end else begin
          bit_d = bit_q + CW'(1);
        end
      end
      S_DRAIN: begin
        if (out_fire) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Accumulator update: clear on a non-accumulating command, otherwise add
  // one bit-plane per COMPUTE cycle; sums wrap modulo 2^ACC_BITS.
  always_comb begin
    acc_d = acc_q;
    if (cmd_fire && !cmd_accumulate) begin
      acc_d = '0;
    end else if (state_q == S_COMPUTE) begin
      for (int i = 0; i < ROWS; i++) begin
        for (int j = 0; j < COLS; j++) begin
          if (b_bit[j]) begin
            acc_d[(i*COLS+j)*ACC_BITS +: ACC_BITS] =
              acc_q[(i*COLS+j)*ACC_BITS +: ACC_BITS] + a_shift[i];
          end
        end
      end
    end
  end

  // Output flags are decoded from the next state so they are registered.
  always_comb begin
    cmd_ready_d = (state_d == S_IDLE);
    op_ready_d  = (state_d == S_LOAD);
    out_valid_d = (state_d == S_DRAIN);
    busy_d      = (state_d != S_IDLE);
  end

  // State, datapath and registered-output flops with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      step_q      <= '0;
      bit_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      cmd_ready_q <= 1'b1;
      op_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      step_q      <= step_d;
      bit_q       <= bit_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      cmd_ready_q <= cmd_ready_d;
      op_ready_q  <= op_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign op_ready  = op_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_acc   = acc_q;

endmodule

// File: doc/tau_gemm_stream.md
# tau_gemm_stream

Parametrised, streaming successor to the square bit-serial GEMM array: computes an unsigned ROWS x COLS outer-product accumulation over a runtime-selected inner dimension K. Operand vectors arrive one k-step at a time over a valid/ready stream rather than as whole matrices. Results are held behind a valid/ready output port. The block sits between the operand buffers and the result writeback in the MAC datapath.

## Interface
- ROWS, default 4: rows of the result (length of A column vector)
- COLS, default 4: columns of the result (length of B row vector)
- WIDTH, default 8: operand bit width; one k-step takes WIDTH compute cycles
- MAX_K, default 16: largest supported inner dimension
- ACC_BITS, default 2*WIDTH+$clog2(MAX_K)+1: accumulator width
- clk  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when both high
- cmd_k_len  in  $clog2(MAX_K)+1  inner dimension K for this command
- cmd_accumulate  in  1  1: add onto existing accumulators; 0: clear first
- op_valid  in  1  operand beat offered
- op_ready  out  1  operand beat accepted when both high
- op_a  in  ROWS*WIDTH  A column k, element i at [i*WIDTH +: WIDTH]
- op_b  in  COLS*WIDTH  B row k, element j at [j*WIDTH +: WIDTH]
- out_valid  out  1  result available
- out_ready  in  1  result consumed when both high
- out_acc  out  ROWS*COLS*ACC_BITS  accumulator (i,j) at [(i*COLS+j)*ACC_BITS +: ACC_BITS]
- busy  out  1  high whenever state is not IDLE

## Operation
- States: IDLE, LOAD, COMPUTE, DRAIN.
- IDLE: cmd_ready=1. On cmd handshake, latch K = min(cmd_k_len, MAX_K) and zero the step counter. If cmd_accumulate=0, clear all accumulators on the same edge. Go to DRAIN if K=0, else LOAD.
- LOAD: op_ready=1. On op handshake, latch op_a/op_b, zero the bit counter, and go to COMPUTE. op_valid gaps simply extend LOAD.
- COMPUTE: runs WIDTH cycles with bit counter c = 0..WIDTH-1. Each cycle, for all i,j: acc[i][j] += b[j][c] ? (a[i] << c) : 0. All arithmetic is unsigned and modulo 2^ACC_BITS.
- End of COMPUTE, on the edge closing the c=WIDTH-1 cycle: if step == K-1 go to DRAIN, else increment step and go to LOAD.
- DRAIN: out_valid=1. out_acc must stay stable until out_ready. On out handshake go to IDLE.
- cmd_ready=0 and op_ready=0 outside IDLE and LOAD respectively. Beats offered at other times are ignored, not queued.
- out_acc continuously reflects the accumulator registers; its contents are meaningful only while out_valid=1.
- Accumulators persist across commands. The accumulate=1 path chains partial sums over multiple commands.

## Timing
- Reset values: state IDLE, all accumulators 0, out_acc 0, out_valid 0, op_ready 0, busy 0, cmd_ready 1 in the first cycle after reset.
- Reset asserted in any state, including mid-COMPUTE or DRAIN, aborts the operation. The block returns to IDLE on that edge with accumulators cleared.
- Call the cmd handshake edge E.
- With op_valid held high and out_ready low, out_valid first reads 1 in the cycle following edge E + K*(WIDTH+1). K=0 gives the cycle directly after E.
- Per-step throughput: WIDTH+1 cycles (one LOAD cycle plus WIDTH COMPUTE cycles) at best.
- Back-to-back commands: out handshake at edge D returns to IDLE, so cmd_ready=1 in the cycle after D. This gives minimum one idle cycle between results.
- Overflow: no overflow occurs for a single accumulate=0 command with K <= MAX_K. Chained accumulation wraps silently.

## Test plan
- Reset then idle: cmd_ready=1, out_valid=0, busy=0, out_acc all 0. Assert reset mid-COMPUTE -> next cycle is IDLE with accumulators 0 and out_valid=0.
- ROWS=COLS=2, WIDTH=8, K=1, accumulate=0, a=(3,5), b=(7,255), op_valid held high -> out_valid first high 9 cycles after E; out_acc = (21, 765, 35, 1275).
- Same operands but K=2, second beat a=(1,1), b=(1,2) -> out_valid after 18 cycles; out_acc = (22, 767, 36, 1277). Then issue K=1, accumulate=1, a=(1,0), b=(1,1) -> (23, 768, 36, 1277).
- Backpressure: insert 3-cycle op_valid gaps -> latency grows by exactly 3 per gap. Hold out_ready low 10 cycles -> out_acc stable and cmd_ready=0 throughout.
- K=0 with accumulate=0 -> out_valid in the cycle after E with all zeros. cmd_k_len = MAX_K+5 -> exactly MAX_K operand beats accepted.
- Worst case: MAX_K=16, all a,b = 255, K=16 -> every accumulator = 16*65025 = 1040400 with no wrap. Repeating with accumulate=1 until wrap -> value mod 2^ACC_BITS.
